io_switch_conditioner: RTL and testbench
========================================

IO_SWITCH_CONDITIONER -- requirements
Module: io_switch_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 50000; consecutive cycles a synchronized input must differ from its stable value before that stable value changes; legal range 2..(2^CNT_W - 1).
REQ-002 Parameter CNT_W, default 16; width of each debounce counter.
REQ-003 Port clock  input  1  single clock; all state changes on its rising edge.
REQ-004 Port resetn  input  1  reset, asynchronous, active-low.
REQ-005 Port sw  input  10  raw board slide switches; asynchronous to clock.
REQ-006 Port key0_n  input  1  raw push-button, active-low (0 = pressed); asynchronous to clock.
REQ-007 Port clr_event  input  1  single-cycle pulse from the CPU side; clears the key event flag.
REQ-008 Port in_port0  output  32  conditioned operand 0, feeds the CPU I/O read path.
REQ-009 Port in_port1  output  32  conditioned operand 1, feeds the CPU I/O read path.

Function
REQ-010 Each of the 11 raw inputs (sw[9:0], key0_n) SHALL pass through its own two-flop synchronizer before any other use.
REQ-011 Each synchronized bit SHALL have its own stable bit and its own CNT_W-bit counter.
REQ-012 Counter behaviour per bit: synchronized == stable -> counter cleared to 0; differs and counter < DEBOUNCE_CYCLES-1 -> counter +1; differs and counter == DEBOUNCE_CYCLES-1 -> stable takes the synchronized value, counter cleared.
REQ-013 Latency: a pin level first sampled at edge k and held steady SHALL appear in the stable bit after edge k+DEBOUNCE_CYCLES+1, and not earlier.
REQ-014 A pin pulse whose synchronized width is shorter than DEBOUNCE_CYCLES cycles SHALL NOT change the stable bit.
REQ-015 A bounce back to the stable level SHALL clear that bit's counter; debounce timing then restarts from 0.
REQ-016 Counters SHALL never wrap; the maximum value reached is DEBOUNCE_CYCLES-1.
REQ-017 in_port0 SHALL equal {27'b0, stable_sw[4:0]} and in_port1 SHALL equal {27'b0, stable_sw[9:5]}, except for the bits given in REQ-022.
REQ-018 Outputs SHALL be driven directly from the stable-bit registers, with no combinational path from sw or key0_n.
REQ-019 Bits are independent: simultaneous changes on several pins SHALL each debounce on their own counters.

Reset
REQ-020 While resetn = 0, the following SHALL be held at these values regardless of clock:
- all synchronizer flops for sw at 0, and for key0_n at 1;
- all counters at 0;
- stable_sw at 0 and stable_key at 1;
- event flag at 0;
- in_port0 and in_port1 at 32'h0.
REQ-021 Reset asserted in the middle of a debounce SHALL abandon it; after release, debouncing restarts from counter 0 against the reset stable values.

Configuration
REQ-022 Macro IO_KEY_EVENT_EN, when defined, SHALL enable the following:
- in_port0[31] = sticky press-event flag;
- in_port0[30] = ~stable_key (1 while the button is debounced-pressed).
REQ-023 The event flag SHALL be set on the edge where stable_key changes 1->0, and cleared on an edge where clr_event = 1 and no such change occurs; if both happen on the same edge, set wins.
REQ-024 Without IO_KEY_EVENT_EN:
- in_port0[31:30] SHALL be 0;
- key0_n and clr_event SHALL be ignored;
- no key synchronizer, counter or flag logic SHALL exist.

Verification (DEBOUNCE_CYCLES=4, CNT_W=4)
REQ-025 Reset release, all inputs static: sw=0, key0_n=1 -> in_port0 = in_port1 = 32'h0 on every cycle.
REQ-026 sw steps 0 -> 10'h3FF at sampling edge k and holds -> in_port0 = in_port1 = 32'h1F, first visible after edge k+5 and not after edge k+4.
REQ-027 sw[0] glitches high for 3 cycles, then a 0 for 1 cycle, then high steady -> in_port0 stays 0 through the glitch; it becomes 1 exactly 5 edges after the final rise is sampled.
REQ-028 IO_KEY_EVENT_EN defined, key0_n held low for 10 cycles -> in_port0 = 32'hC000_0000 after debounce; after release and debounce, 32'h8000_0000; clr_event pulse -> 32'h0.
REQ-029 IO_KEY_EVENT_EN defined, clr_event asserted on the same edge as the debounced press -> flag = 1 afterwards.
REQ-030 resetn pulsed low mid-debounce (counter = 2) -> outputs 0 immediately (asynchronous); after release, the change needs the full 5-edge latency again.

Source files
------------

// File: rtl/io_switch_conditioner_if.sv
// Board I/O bundle between the raw switch/button pins and the CPU read path.
// Carries raw inputs in, conditioned operand words out.
interface io_switch_conditioner_if;
    logic [9:0]  sw;
    logic        key0_n;
    logic        clr_event;
    logic [31:0] in_port0;
    logic [31:0] in_port1;

    modport master (
        output sw,
        output key0_n,
        output clr_event,
        input  in_port0,
        input  in_port1
    );

    modport slave (
        input  sw,
        input  key0_n,
        input  clr_event,
        output in_port0,
        output in_port1
    );
endinterface

// File: rtl/io_switch_conditioner.sv
// Synchronizes and debounces slide switches (and optionally KEY0) into CPU operand words.
// Optional feature macro: IO_KEY_EVENT_EN adds KEY0 debounce and a sticky press-event flag.
module io_switch_conditioner #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic                   clock,
    input  logic                   resetn,
    io_switch_conditioner_if.slave bus
);

`ifdef IO_KEY_EVENT_EN
    localparam int            NB      = 11;
    localparam logic [NB-1:0] RST_VAL = 11'h400;
`else
    localparam int            NB      = 10;
    localparam logic [NB-1:0] RST_VAL = 10'h000;
`endif

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NB-1:0]    raw;
    logic [NB-1:0]    sync1_d, sync1_q;
    logic [NB-1:0]    sync2_d, sync2_q;
    logic [NB-1:0]    stable_d, stable_q;
    logic [CNT_W-1:0] cnt_d [NB];
    logic [CNT_W-1:0] cnt_q [NB];

`ifdef IO_KEY_EVENT_EN
    assign raw = {bus.key0_n, bus.sw};
`else
    assign raw = bus.sw;
`endif

    // Two-flop synchronizer chain for every raw pin
    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
    end

    // Per-bit debounce: count consecutive disagreeing samples, commit on the last one
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < NB; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Synchronizer, stable and counter registers
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync1_q  <= RST_VAL;
            sync2_q  <= RST_VAL;
            stable_q <= RST_VAL;
            for (int i = 0; i < NB; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            for (int i = 0; i < NB; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

`ifdef IO_KEY_EVENT_EN
    logic flag_d, flag_q;
    logic press;

    // A debounced 1->0 on the key sets the flag; set beats a same-edge clear
    always_comb begin
        press  = stable_q[10] & ~stable_d[10];
        flag_d = press | (flag_q & ~bus.clr_event);
    end

    // Sticky press-event flag register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            flag_q <= 1'b0;
        end else begin
            flag_q <= flag_d;
        end
    end

    // Operand words come straight from registers only
    always_comb begin
        bus.in_port0 = {flag_q, ~stable_q[10], 25'b0, stable_q[4:0]};
        bus.in_port1 = {27'b0, stable_q[9:5]};
    end
`else
    logic unused_key_pins;
    assign unused_key_pins = bus.key0_n ^ bus.clr_event;

    // Operand words come straight from registers only
    always_comb begin
        bus.in_port0 = {27'b0, stable_q[4:0]};
        bus.in_port1 = {27'b0, stable_q[9:5]};
    end
`endif

endmodule

// File: tb/tb_io_switch_conditioner.sv
// Scoreboard bench for io_switch_conditioner with DEBOUNCE_CYCLES=4, CNT_W=4.
// Directed phases plus random toggling, checked against a run-length reference model.
module tb_io_switch_conditioner;

    localparam int DEB = 4;
`ifdef IO_KEY_EVENT_EN
    localparam bit KEY_EN = 1'b1;
`else
    localparam bit KEY_EN = 1'b0;
`endif

    logic clock;
    logic resetn;

    io_switch_conditioner_if bus ();

    io_switch_conditioner #(
        .DEBOUNCE_CYCLES (DEB),
        .CNT_W           (4)
    ) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    logic [63:0] exp_q [$];

    // Reference state: pins reach the debouncer two edges after sampling;
    // a stable bit flips after DEB consecutive disagreeing delivered samples.
    bit st   [11];
    bit h1   [11];
    bit h2   [11];
    int run  [11];
    bit flag;

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 11; i++) begin
            st[i]  = (i == 10);
            h1[i]  = st[i];
            h2[i]  = st[i];
            run[i] = 0;
        end
        flag = 1'b0;
    endtask

    function automatic logic [63:0] model_out();
        logic [31:0] p0;
        logic [31:0] p1;
        p0 = '0;
        p1 = '0;
        for (int i = 0; i < 5; i++) begin
            p0[i] = st[i];
            p1[i] = st[i+5];
        end
        if (KEY_EN) begin
            p0[31] = flag;
            p0[30] = ~st[10];
        end
        return {p0, p1};
    endfunction

    task automatic model_edge(input logic [9:0] s, input logic k, input logic c);
        bit pin [11];
        bit seen;
        bit prev_key;
        int nb;
        nb = KEY_EN ? 11 : 10;
        prev_key = st[10];
        for (int i = 0; i < 10; i++) pin[i] = s[i];
        pin[10] = k;
        for (int i = 0; i < nb; i++) begin
            seen  = h2[i];
            h2[i] = h1[i];
            h1[i] = pin[i];
            if (seen != st[i]) begin
                run[i]++;
                if (run[i] == DEB) begin
                    st[i]  = seen;
                    run[i] = 0;
                end
            end else begin
                run[i] = 0;
            end
        end
        if (KEY_EN) begin
            if (prev_key && !st[10]) flag = 1'b1;
            else if (c) flag = 1'b0;
        end
        exp_q.push_back(model_out());
    endtask

    // One clock cycle: inputs set mid-cycle, model advanced at the edge
    task automatic cyc(input logic [9:0] s, input logic k, input logic c);
        bus.sw        = s;
        bus.key0_n    = k;
        bus.clr_event = c;
        @(posedge clock);
        model_edge(s, k, c);
        #2;
    endtask

    // Monitor: compare each registered output against the queued expectation
    always @(negedge clock) begin
        if (resetn && exp_q.size() > 0) begin
            logic [63:0] e;
            e = exp_q.pop_front();
            check("in_port0", bus.in_port0, e[63:32]);
            check("in_port1", bus.in_port1, e[31:0]);
        end
    end

    initial begin
        logic [9:0] s;
        logic       k;
        logic       c;
        int         b;

        resetn        = 1'b0;
        bus.sw        = '0;
        bus.key0_n    = 1'b1;
        bus.clr_event = 1'b0;
        model_reset();
        #3;
        check("reset_p0", bus.in_port0, 32'h0);
        check("reset_p1", bus.in_port1, 32'h0);
        repeat (3) @(posedge clock);
        #2;
        resetn = 1'b1;

        // Static inputs
        repeat (8) cyc(10'h000, 1'b1, 1'b0);

        // Full step and back
        repeat (10) cyc(10'h3FF, 1'b1, 1'b0);
        repeat (10) cyc(10'h000, 1'b1, 1'b0);

        // Glitch on sw[0]: 3 high, 1 low, then steady high
        repeat (3) cyc(10'h001, 1'b1, 1'b0);
        cyc(10'h000, 1'b1, 1'b0);
        repeat (8) cyc(10'h001, 1'b1, 1'b0);
        repeat (8) cyc(10'h000, 1'b1, 1'b0);

        // Key press, release, clear
        repeat (10) cyc(10'h000, 1'b0, 1'b0);
        repeat (10) cyc(10'h000, 1'b1, 1'b0);
        cyc(10'h000, 1'b1, 1'b1);
        repeat (3) cyc(10'h000, 1'b1, 1'b0);

        // Clear on the same edge as the debounced press
        for (int j = 0; j < 10; j++) cyc(10'h000, 1'b0, j == DEB + 1);
        repeat (8) cyc(10'h000, 1'b1, 1'b0);
        cyc(10'h000, 1'b1, 1'b1);
        repeat (2) cyc(10'h000, 1'b1, 1'b0);

        // Reset in the middle of a debounce
        repeat (8) cyc(10'h3FF, 1'b1, 1'b0);
        repeat (4) cyc(10'h000, 1'b1, 1'b0);
        resetn = 1'b0;
        exp_q.delete();
        #1;
        check("async_rst_p0", bus.in_port0, 32'h0);
        check("async_rst_p1", bus.in_port1, 32'h0);
        bus.sw = 10'h3FF;
        repeat (2) @(posedge clock);
        #2;
        model_reset();
        resetn = 1'b1;
        repeat (10) cyc(10'h3FF, 1'b1, 1'b0);

        // Random toggling: mixes short glitches with settled levels
        s = 10'h3FF;
        k = 1'b1;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(3) == 0) begin
                b = $urandom_range(9);
                s[b] = ~s[b];
            end
            if ($urandom_range(4) == 0) k = ~k;
            c = ($urandom_range(7) == 0);
            cyc(s, k, c);
        end

        repeat (2) @(negedge clock);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
